// File: rtl/telem_pkg.sv
// rtl/telem_pkg.sv - constants, status packing and FSM states for segway_telem_tx; TELEM_CKSUM_EN selects 5-byte frames
package telem_pkg;

    localparam logic [7:0] TELEM_HDR = 8'hA5;

    localparam int STAT_PWR_UP    = 0;
    localparam int STAT_RIDER_OFF = 1;
    localparam int STAT_TOO_FAST  = 3;

    localparam int FRAME_LEN_BASE  = 4;
    localparam int FRAME_LEN_CKSUM = 5;

`ifdef TELEM_CKSUM_EN
    localparam bit CKSUM_EN = 1'b1;
`else
    localparam bit CKSUM_EN = 1'b0;
`endif

    localparam int FRAME_LEN = CKSUM_EN ? FRAME_LEN_CKSUM : FRAME_LEN_BASE;

    typedef enum logic [1:0] {IDLE, LOAD, XMIT, DONE} telem_state_t;

    function automatic logic [7:0] pack_status(input logic pwr_up, input logic rider_off,
                                               input logic too_fast);
        logic [7:0] s;
        s = 8'h00;
        s[STAT_PWR_UP]    = pwr_up;
        s[STAT_RIDER_OFF] = rider_off;
        s[STAT_TOO_FAST]  = too_fast;
        return s;
    endfunction

endpackage

// File: rtl/segway_telem_tx_if.sv
// rtl/segway_telem_tx_if.sv - status inputs and UART/frame outputs of segway_telem_tx
interface segway_telem_tx_if;
    logic        pwr_up;
    logic        rider_off;
    logic        too_fast;
    logic [11:0] batt;
    logic        send_now;
    logic        TX;
    logic        busy;
    logic        frame_done;

    modport master (output pwr_up, rider_off, too_fast, batt, send_now,
                    input  TX, busy, frame_done);
    modport slave  (input  pwr_up, rider_off, too_fast, batt, send_now,
                    output TX, busy, frame_done);
endinterface

// File: rtl/telem_uart_ser.sv
// rtl/telem_uart_ser.sv - 8N1 LSB-first byte serializer; trmt on byte_done reloads with no idle gap
module telem_uart_ser #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       byte_done
);
    localparam int BW = $clog2(BAUD_DIV);

    logic [9:0]    shift;
    logic [BW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;
    logic          active;
    logic          bit_end;

    assign bit_end   = active && (baud_cnt == BW'(BAUD_DIV - 1));
    assign byte_done = bit_end && (bit_cnt == 4'd9);
    assign tx        = shift[0];

    // Shifting ones in from the top leaves the line idle-high once the stop bit is out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift    <= '1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            active   <= 1'b0;
        end else if (trmt) begin
            shift    <= {1'b1, tx_data, 1'b0};
            baud_cnt <= '0;
            bit_cnt  <= '0;
            active   <= 1'b1;
        end else if (bit_end) begin
            shift    <= {1'b1, shift[9:1]};
            baud_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
            if (byte_done)
                active <= 1'b0;
        end else if (active) begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/segway_telem_tx.sv
// rtl/segway_telem_tx.sv - periodic/on-demand telemetry frame transmitter; TELEM_CKSUM_EN appends a checksum byte
module segway_telem_tx
    import telem_pkg::*;
#(
    parameter int BAUD_DIV    = 2604,
    parameter int PERIOD_CLKS = 5_000_000
) (
    input  logic               clk,
    input  logic               rst,
    segway_telem_tx_if.slave   tif
);
    localparam int PW = $clog2(PERIOD_CLKS);

    telem_state_t  state, state_n;
    logic          pwr_q, pending, trig, per_hit, last_byte, trmt, byte_done;
    logic [PW-1:0] per_cnt;
    logic [3:0]    seq, seq_q;
    logic [7:0]    stat_q, tx_byte, nxt_byte;
    logic [11:0]   batt_q;
    logic [2:0]    byte_idx, nxt_idx;

    assign per_hit   = per_cnt == PW'(PERIOD_CLKS - 1);
    assign trig      = tif.send_now | per_hit | (tif.pwr_up ^ pwr_q);
    assign last_byte = byte_idx == 3'(FRAME_LEN - 1);
    assign nxt_idx   = byte_idx + 3'd1;

`ifdef TELEM_CKSUM_EN
    logic [7:0] cksum;
    assign cksum = 8'd0 - (TELEM_HDR + stat_q + batt_q[11:4] + {batt_q[3:0], seq_q});
`endif

    always_comb begin
        nxt_byte = TELEM_HDR;
        case (nxt_idx)
            3'd1:    nxt_byte = stat_q;
            3'd2:    nxt_byte = batt_q[11:4];
            3'd3:    nxt_byte = {batt_q[3:0], seq_q};
`ifdef TELEM_CKSUM_EN
            3'd4:    nxt_byte = cksum;
`endif
            default: nxt_byte = TELEM_HDR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // DONE goes straight to LOAD when work is queued so the follow-on frame loses no cycle.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (trig || pending) state_n = LOAD;
            LOAD:    state_n = XMIT;
            XMIT:    if (byte_done && last_byte) state_n = DONE;
            DONE:    state_n = (trig || pending) ? LOAD : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        trmt           = 1'b0;
        tx_byte        = TELEM_HDR;
        tif.busy       = state != IDLE;
        tif.frame_done = state == DONE;
        case (state)
            LOAD: trmt = 1'b1;
            XMIT: if (byte_done && !last_byte) begin
                trmt    = 1'b1;
                tx_byte = nxt_byte;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwr_q    <= 1'b0;
            pending  <= 1'b0;
            per_cnt  <= '0;
            seq      <= '0;
            seq_q    <= '0;
            stat_q   <= '0;
            batt_q   <= '0;
            byte_idx <= '0;
        end else begin
            pwr_q   <= tif.pwr_up;
            per_cnt <= (state_n == LOAD || per_hit) ? '0 : per_cnt + 1'b1;
            if (state == LOAD)
                pending <= trig;
            else if (state != IDLE)
                pending <= pending | trig;
            if (state == DONE)
                seq <= seq + 4'd1;
            if (state == LOAD) begin
                stat_q   <= pack_status(tif.pwr_up, tif.rider_off, tif.too_fast);
                batt_q   <= tif.batt;
                seq_q    <= seq;
                byte_idx <= '0;
            end else if (trmt) begin
                byte_idx <= nxt_idx;
            end
        end
    end

    telem_uart_ser #(.BAUD_DIV(BAUD_DIV)) u_ser (
        .clk       (clk),
        .rst       (rst),
        .trmt      (trmt),
        .tx_data   (tx_byte),
        .tx        (tif.TX),
        .byte_done (byte_done)
    );
endmodule

// File: tb/tb_segway_telem_tx.sv
// tb/tb_segway_telem_tx.sv - self-checking bench for segway_telem_tx with a UART line decoder and frame model
module tb_segway_telem_tx;
    localparam int B = 4;
    localparam int P = 4000;
`ifdef TELEM_CKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif
    localparam int FRAME_CLKS = NB * 10 * B;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    int   model_seq = 0;
    int   load_cyc = 0;
    int   fd_at, fd_extra, frm_err, busy_drop;
    logic [7:0] rx_b [5];
    logic [7:0] exp_b [5];

    segway_telem_tx_if tif();

    segway_telem_tx #(.BAUD_DIV(B), .PERIOD_CLKS(P)) dut (
        .clk (clk),
        .rst (rst),
        .tif (tif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Expected frame from the current inputs and the bench's own frame counter.
    task automatic build_exp();
        int sum;
        exp_b[0] = 8'hA5;
        exp_b[1] = 8'(tif.too_fast * 8 + tif.rider_off * 2 + tif.pwr_up);
        exp_b[2] = 8'(tif.batt / 16);
        exp_b[3] = 8'((tif.batt % 16) * 16 + model_seq);
        sum = 0;
        for (int i = 0; i < 4; i++) sum += exp_b[i];
        exp_b[4] = 8'((256 - sum % 256) % 256);
    endtask

    task automatic pulse_start(input string tag, input bit do_pulse);
        int w;
        if (do_pulse) tif.send_now = 1'b1;
        @(negedge clk);
        tif.send_now = 1'b0;
        load_cyc = cyc;
        check($sformatf("%s_load", tag), {tif.busy, tif.TX}, 2'b11);
        @(negedge clk);
        check($sformatf("%s_start", tag), tif.TX, 1'b0);
        w = 0;
        while (tif.TX !== 1'b0 && w < 200) begin
            @(negedge clk);
            w++;
        end
    endtask

    // Caller sits on the first negedge with the start bit low; returns at the frame_done negedge.
    task automatic rx_frame(input int p0, input int p1, input int p2,
                            input int chg_at, input logic [11:0] chg_val);
        logic bits [$];
        fd_at = -1; fd_extra = 0; busy_drop = 0; frm_err = 0;
        for (int t = 0; t <= FRAME_CLKS; t++) begin
            if (t > 0) @(negedge clk);
            tif.send_now = (t == p0 || t == p1 || t == p2);
            if (t == chg_at) tif.batt = chg_val;
            if (t < FRAME_CLKS && t % B == 2) bits.push_back(tif.TX);
            if (tif.frame_done === 1'b1) begin
                if (fd_at < 0) fd_at = t;
                else fd_extra++;
            end
            if (tif.busy !== 1'b1) busy_drop++;
        end
        tif.send_now = 1'b0;
        for (int k = 0; k < NB; k++) begin
            if (bits[k*10] !== 1'b0 || bits[k*10+9] !== 1'b1) frm_err++;
            for (int i = 0; i < 8; i++) rx_b[k][i] = bits[k*10+1+i];
        end
    endtask

    task automatic cmp_frame(input string tag);
        for (int k = 0; k < NB; k++)
            check($sformatf("%s_byte%0d", tag, k), rx_b[k], exp_b[k]);
        check($sformatf("%s_done_at", tag), fd_at, FRAME_CLKS);
        check($sformatf("%s_framing", tag), fd_extra + busy_drop + frm_err, 0);
        model_seq = (model_seq + 1) % 16;
    endtask

    task automatic expect_idle(input string tag, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tif.busy !== 1'b0 || tif.TX !== 1'b1 || tif.frame_done !== 1'b0) bad++;
        end
        check(tag, bad, 0);
    endtask

    initial begin
        int k;
        int bad;
        tif.pwr_up    = 1'b0;
        tif.rider_off = 1'b0;
        tif.too_fast  = 1'b0;
        tif.batt      = 12'($urandom);
        tif.send_now  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {tif.TX, tif.busy, tif.frame_done}, 3'b100);

        // First periodic frame after reset release
        rst = 1'b0;
        build_exp();
        k = 0;
        bad = 0;
        do begin
            @(negedge clk);
            k++;
            if (k < P && (tif.busy !== 1'b0 || tif.TX !== 1'b1)) bad++;
        end while (tif.TX !== 1'b0 && k < P + 100);
        check("periodic_quiet", bad, 0);
        check("periodic_start", k, P + 1);
        rx_frame(-1, -1, -1, -1, 12'h000);
        cmp_frame("periodic");

        // send_now with a simultaneous pwr_up edge gives a single frame
        expect_idle("idle_a", 4);
        tif.batt = 12'hABC; tif.pwr_up = 1'b1; tif.rider_off = 1'b0; tif.too_fast = 1'b0;
        build_exp();
        pulse_start("abc", 1'b1);
        rx_frame(-1, -1, -1, -1, 12'h000);
        cmp_frame("abc");
        expect_idle("abc_single", 10);

        // Three requests mid-frame collapse into one follow-on frame
        tif.batt = 12'($urandom); tif.rider_off = 1'($urandom); tif.too_fast = 1'($urandom);
        build_exp();
        pulse_start("coll", 1'b1);
        rx_frame(7, 61, 113, -1, 12'h000);
        cmp_frame("coll");
        build_exp();
        pulse_start("coll_fo", 1'b0);
        rx_frame(-1, -1, -1, -1, 12'h000);
        cmp_frame("coll_fo");
        expect_idle("coll_single", 10);

        // batt changes during byte1 do not reach the frame in flight
        tif.batt = 12'h100;
        build_exp();
        pulse_start("snap", 1'b1);
        rx_frame(-1, -1, -1, 10 * B + 5, 12'hFFF);
        cmp_frame("snap");
        expect_idle("snap_gap", 2);
        build_exp();
        pulse_start("snap2", 1'b1);
        rx_frame(-1, -1, -1, -1, 12'h000);
        cmp_frame("snap2");

        // send_now on the exact cycle the period expires yields one frame
        expect_idle("sim_gap", 2);
        build_exp();
        pulse_start("sim_ref", 1'b1);
        rx_frame(-1, -1, -1, -1, 12'h000);
        cmp_frame("sim_ref");
        k = load_cyc + P - 1;
        while (cyc < k) @(negedge clk);
        tif.batt = 12'($urandom);
        build_exp();
        pulse_start("sim", 1'b1);
        rx_frame(-1, -1, -1, -1, 12'h000);
        cmp_frame("sim");
        expect_idle("sim_single", 20);

        // Reset in the middle of byte2 aborts cleanly
        pulse_start("abort", 1'b1);
        repeat (2 * 10 * B + 5) @(negedge clk);
        rst = 1'b1;
        tif.pwr_up = 1'b0;
        #1;
        check("abort_async_tx", tif.TX, 1'b1);
        @(negedge clk);
        check("abort_outputs", {tif.TX, tif.busy, tif.frame_done}, 3'b100);
        rst = 1'b0;
        model_seq = 0;
        expect_idle("abort_quiet", 3 * FRAME_CLKS);

        // 17 frames: sequence number wraps back to 0
        for (int f = 0; f < 17; f++) begin
            tif.batt = 12'($urandom); tif.rider_off = 1'($urandom); tif.too_fast = 1'($urandom);
            build_exp();
            pulse_start("wrap", 1'b1);
            rx_frame(-1, -1, -1, -1, 12'h000);
            cmp_frame($sformatf("wrap%0d", f));
            if (f == 16) check("seq_wrap", rx_b[3][3:0], 4'd0);
            expect_idle("wrap_gap", 2);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
